// File: rtl/rs_issue_queue_if.sv
// Bundle of the allocation, CDB snoop and dispatch signals around one
// reservation-station issue queue. master = allocation/CDB/FU side,
// slave = the queue itself.
interface rs_issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int FUNC_W = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              flush;

    logic              alloc_valid;
    logic              alloc_ready;
    logic [FUNC_W-1:0] alloc_func;
    logic              alloc_j_rdy;
    logic [DATA_W-1:0] alloc_vj;
    logic [TAG_W-1:0]  alloc_qj;
    logic              alloc_k_rdy;
    logic [DATA_W-1:0] alloc_vk;
    logic [TAG_W-1:0]  alloc_qk;
    logic [TAG_W-1:0]  alloc_rob;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              iss_valid;
    logic              iss_ready;
    logic [FUNC_W-1:0] iss_func;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [TAG_W-1:0]  iss_rob;

    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush,
        output alloc_valid, alloc_func, alloc_j_rdy, alloc_vj, alloc_qj,
        output alloc_k_rdy, alloc_vk, alloc_qk, alloc_rob,
        output cdb_valid, cdb_tag, cdb_data,
        output iss_ready,
        input  alloc_ready,
        input  iss_valid, iss_func, iss_a, iss_b, iss_rob,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  alloc_valid, alloc_func, alloc_j_rdy, alloc_vj, alloc_qj,
        input  alloc_k_rdy, alloc_vk, alloc_qk, alloc_rob,
        input  cdb_valid, cdb_tag, cdb_data,
        input  iss_ready,
        output alloc_ready,
        output iss_valid, iss_func, iss_a, iss_b, iss_rob,
        output occupancy
    );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: age-ordered compacting entry array
// (slot 0 oldest), CDB operand snooping with allocation bypass, and
// dispatch of the oldest fully-ready entry with a stable held offer.
module rs_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int FUNC_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rs_issue_queue_if.slave     q_if
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic              j_rdy;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic              k_rdy;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  rob;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            upper [DEPTH];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              lock_q;
    logic              lock_d;
    logic [IDX_W-1:0]  lock_idx_q;
    logic [IDX_W-1:0]  lock_idx_d;

    logic [DEPTH-1:0]  rdy_vec;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    entry_t            sel_ent;
    logic              xfer;
    logic              accept;
    logic [OCC_W-1:0]  wslot;
    entry_t            alloc_ent;

    // Per-slot eligibility; only slots below occupancy hold live entries.
    // Shift source for each slot is its younger neighbour (top slot has none).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_info
        assign rdy_vec[gi] = (OCC_W'(gi) < occ_q) && ent_q[gi].j_rdy && ent_q[gi].k_rdy;
        if (gi < DEPTH - 1) begin : g_up
            assign upper[gi] = ent_q[gi+1];
        end else begin : g_top
            assign upper[gi] = ent_q[gi];
        end
    end

    // Oldest-ready priority pick over registered state.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    // A held offer stays pinned to its slot so nothing can displace it.
    assign sel_valid = lock_q | pick_found;
    assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
    assign sel_ent   = ent_q[sel_idx];

    assign xfer   = sel_valid & q_if.iss_ready;
    assign accept = q_if.alloc_valid & q_if.alloc_ready;
    assign wslot  = occ_q - (xfer ? OCC_W'(1) : OCC_W'(0));

    assign q_if.alloc_ready = (occ_q < OCC_W'(DEPTH));
    assign q_if.iss_valid   = sel_valid;
    assign q_if.iss_func    = sel_valid ? sel_ent.func : '0;
    assign q_if.iss_a       = sel_valid ? sel_ent.vj   : '0;
    assign q_if.iss_b       = sel_valid ? sel_ent.vk   : '0;
    assign q_if.iss_rob     = sel_valid ? sel_ent.rob  : '0;
    assign q_if.occupancy   = occ_q;

    // New entry, with operands picked straight off the CDB when it matches.
    always_comb begin
        alloc_ent.func  = q_if.alloc_func;
        alloc_ent.j_rdy = q_if.alloc_j_rdy;
        alloc_ent.vj    = q_if.alloc_vj;
        alloc_ent.qj    = q_if.alloc_qj;
        alloc_ent.k_rdy = q_if.alloc_k_rdy;
        alloc_ent.vk    = q_if.alloc_vk;
        alloc_ent.qk    = q_if.alloc_qk;
        alloc_ent.rob   = q_if.alloc_rob;
        if (q_if.cdb_valid && !q_if.alloc_j_rdy && (q_if.alloc_qj == q_if.cdb_tag)) begin
            alloc_ent.j_rdy = 1'b1;
            alloc_ent.vj    = q_if.cdb_data;
        end
        if (q_if.cdb_valid && !q_if.alloc_k_rdy && (q_if.alloc_qk == q_if.cdb_tag)) begin
            alloc_ent.k_rdy = 1'b1;
            alloc_ent.vk    = q_if.cdb_data;
        end
    end

    // Per-slot next state: compact past the removed entry, snoop the CDB at
    // the post-shift position, then drop in the new allocation.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_next
        entry_t nxt_ent;
        always_comb begin
            nxt_ent = (xfer && (IDX_W'(gi) >= sel_idx)) ? upper[gi] : ent_q[gi];
            if (q_if.cdb_valid && !nxt_ent.j_rdy && (nxt_ent.qj == q_if.cdb_tag)) begin
                nxt_ent.j_rdy = 1'b1;
                nxt_ent.vj    = q_if.cdb_data;
            end
            if (q_if.cdb_valid && !nxt_ent.k_rdy && (nxt_ent.qk == q_if.cdb_tag)) begin
                nxt_ent.k_rdy = 1'b1;
                nxt_ent.vk    = q_if.cdb_data;
            end
            if (accept && (wslot == OCC_W'(gi))) begin
                nxt_ent = alloc_ent;
            end
        end
        assign ent_d[gi] = nxt_ent;
    end

    // Occupancy and held-offer bookkeeping.
    always_comb begin
        occ_d      = occ_q + (accept ? OCC_W'(1) : OCC_W'(0)) - (xfer ? OCC_W'(1) : OCC_W'(0));
        lock_d     = sel_valid & ~q_if.iss_ready;
        lock_idx_d = sel_idx;
    end

    // State registers; flush empties the queue and beats every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (q_if.flush) begin
            occ_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            occ_q      <= occ_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule
